adder_tree_acc: RTL and testbench
=================================

Name: adder_tree_acc

Overview:
- Parametrised, fully pipelined successor to the single registered two-input adder.
- Sums M operands of N bits through a registered binary adder tree. Each level widens by one bit, so no level can overflow.
- Feeds a final accumulate stage with optional saturation.
- Sits in the datapath after the sample registers. Used for block sums and running totals with a valid-qualified stream.

Parameters:
N, 8, operand width in bits (>=1)
M, 4, operand count; power of two, >=2
L, log2(M), tree depth; derived localparam, not overridable
SIGNED, 0, 0 = unsigned operands and sums; 1 = two's-complement throughout
ACC_W, N+L+4, accumulator/output width; must be >= N+L

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  qualifies in_data/in_acc/in_clr this cycle
in_data  input  M*N  operand i at bits [i*N +: N]
in_acc  input  1  1 = add this sample's tree sum into accumulator; 0 = pass-through
in_clr  input  1  with in_acc=1: accumulator restarts at this sample's sum
out_valid  output  1  out_sum/out_sat valid this cycle
out_sum  output  ACC_W  result, sign/zero-extended per SIGNED
out_sat  output  1  sticky saturation flag for current accumulation run

Behaviour:
- Reset: asynchronous on rst_n low. out_valid=0, out_sum=0, out_sat=0, accumulator=0, all pipeline valid bits=0, tree data registers=0.
- Reset mid-operation flushes every in-flight sample. No out_valid pulse is produced for samples accepted before reset.
- Tree level k (1..L): pairwise adds of level k-1 results, registered, width N+k. Operands are extended by one bit (sign or zero per SIGNED) before each add.
- Level L holds the single tree sum of width N+L. It is exact for all inputs.
- Valid, in_acc and in_clr travel in a shift pipeline alongside the data, one register per level.
- Bubbles (in_valid=0) propagate as invalid slots. Data registers may update on bubbles, but the accumulator must not.
- Accumulate stage: one register after level L. Total latency = L+1 cycles, in_valid to out_valid. Throughput is one sample per cycle, with no stall or backpressure.
- On a valid slot, the tree sum S is extended to ACC_W, then:
  - acc=0: out_sum=S, accumulator=S, out_sat=0.
  - acc=1, clr=1: out_sum=S, accumulator=S, out_sat=0. The run restarts.
  - acc=1, clr=0: T=accumulator+S, computed at ACC_W+1 bits.
    - If T exceeds the ACC_W range, the result clamps to the range limit. Limits are max=2^ACC_W-1 and min=0 (SIGNED=0), or max=2^(ACC_W-1)-1 and min=-2^(ACC_W-1) (SIGNED=1). out_sat is set to 1.
    - Otherwise the result is T and out_sat holds its previous value.
    - out_sum and accumulator take the result.
- Invalid slot: out_valid=0; out_sum, out_sat and the accumulator hold.
- out_sat stays 1 until the next valid sample with acc=0 or clr=1.
- Saturated accumulator values are the starting point for further adds, so the result can later move away from the rail.
- in_clr with in_acc=0 is ignored (it behaves as pass-through).

Decomposition:
- Package adder_tree_pkg:
  - clog2 function
  - ext function: sign/zero-extend by SIGNED
  - saturation-limit constants as functions of ACC_W and SIGNED
- Sub-module adder_stage #(W, K, SIGNED):
  - K inputs of W bits, K/2 registered outputs of W+1 bits, plus valid/ctrl register pass-through.
  - Instantiated L times via generate with W=N+k-1, K=M>>(k-1).
- Top level contains the generate loop and the accumulate stage only.

Test Plan:
- Pass-through, N=8, M=4, SIGNED=0: operands {255,255,255,255}, in_acc=0 -> out_sum=1020 and out_valid exactly 3 cycles later; out_sat=0.
- Signed, SIGNED=1, N=8, M=4: operands {-128,-128,-128,-128} -> out_sum=-512 sign-extended; operands {127,-1,0,1} -> 127.
- Back-to-back with bubbles: valid pattern 1,0,1,1 with sums 10,20,30 -> out_valid pattern 1,0,1,1 delayed by L+1; values 10,20,30 in order.
- Accumulation, ACC_W=14 unsigned: clr sample sum 1000, then 15 acc samples of 1000 each -> values 1000..16000 step 1000; the next sample saturates to 16383 with out_sat=1; a following clr sample of 5 -> out_sum=5, out_sat=0.
- Signed saturation, ACC_W=10: repeated sums of -200 -> -200, -400; the next saturates at -512 with out_sat=1; a subsequent +100 -> -412 with out_sat still 1.
- Async reset asserted mid-stream with 3 samples in flight -> out_valid, out_sum and out_sat read 0 immediately; after release, no stale out_valid; the first new sample appears after L+1 cycles.

Source files
------------

// File: rtl/adder_tree_pkg.sv
`default_nettype none
// =============================================================================
// Module   : adder_tree_pkg
// Brief    : Shared helpers for the pipelined adder tree / accumulator.
// Revision : 1.0 - initial release
// =============================================================================
package adder_tree_pkg;

    localparam int LIM_W = 128;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Extension bit for widening an operand: its MSB when signed, else zero.
    function automatic logic ext(input logic msb, input bit sgn);
        return msb & sgn;
    endfunction

    function automatic logic [LIM_W-1:0] sat_max(input int w, input bit sgn);
        if (sgn) return (LIM_W'(1) << (w - 1)) - LIM_W'(1);
        else     return (LIM_W'(1) << w) - LIM_W'(1);
    endfunction

    function automatic logic [LIM_W-1:0] sat_min(input int w, input bit sgn);
        if (sgn) return LIM_W'(0) - (LIM_W'(1) << (w - 1));
        else     return LIM_W'(0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_tree_acc_if.sv
`default_nettype none
// =============================================================================
// Module   : adder_tree_acc_if
// Brief    : Sample stream in, accumulated result stream out.
// Revision : 1.0 - initial release
// =============================================================================
interface adder_tree_acc_if
    import adder_tree_pkg::*;
#(
    parameter int N     = 8,
    parameter int M     = 4,
    parameter int ACC_W = N + clog2(M) + 4
);
    logic               in_valid;
    logic [M*N-1:0]     in_data;
    logic               in_acc;
    logic               in_clr;
    logic               out_valid;
    logic [ACC_W-1:0]   out_sum;
    logic               out_sat;

    modport master (
        output in_valid, in_data, in_acc, in_clr,
        input  out_valid, out_sum, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_acc, in_clr,
        output out_valid, out_sum, out_sat
    );
endinterface
`default_nettype wire

// File: rtl/adder_stage.sv
`default_nettype none
// =============================================================================
// Module   : adder_stage
// Brief    : One registered level of the adder tree: K operands -> K/2 sums.
// Revision : 1.0 - initial release
// =============================================================================
module adder_stage
    import adder_tree_pkg::*;
#(
    parameter int W      = 8,
    parameter int K      = 4,
    parameter int SIGNED = 0
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic [K*W-1:0]           i_data,
    input  wire logic                     i_valid,
    input  wire logic                     i_acc,
    input  wire logic                     i_clr,
    output logic      [(K/2)*(W+1)-1:0]   o_data,
    output logic                          o_valid,
    output logic                          o_acc,
    output logic                          o_clr
);
    localparam int OW    = W + 1;
    localparam int P     = K / 2;
    localparam bit c_SGN = (SIGNED != 0);

    logic r_valid;
    logic r_acc;
    logic r_clr;

    for (genvar p = 0; p < P; p++) begin : g_pair
        logic [W-1:0]  w_a;
        logic [W-1:0]  w_b;
        logic [OW-1:0] w_sum;
        logic [OW-1:0] r_sum;

        assign w_a   = i_data[(2*p)*W +: W];
        assign w_b   = i_data[(2*p+1)*W +: W];
        // One extra bit per level keeps the pairwise add exact.
        assign w_sum = {ext(w_a[W-1], c_SGN), w_a} + {ext(w_b[W-1], c_SGN), w_b};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_sum <= '0;
            else        r_sum <= w_sum;
        end

        assign o_data[p*OW +: OW] = r_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_acc   <= 1'b0;
            r_clr   <= 1'b0;
        end else begin
            r_valid <= i_valid;
            r_acc   <= i_acc;
            r_clr   <= i_clr;
        end
    end

    assign o_valid = r_valid;
    assign o_acc   = r_acc;
    assign o_clr   = r_clr;

endmodule
`default_nettype wire

// File: rtl/adder_tree_acc.sv
`default_nettype none
// =============================================================================
// Module   : adder_tree_acc
// Brief    : Pipelined M-operand adder tree feeding a saturating accumulator.
// Revision : 1.0 - initial release
// =============================================================================
module adder_tree_acc
    import adder_tree_pkg::*;
#(
    parameter int N      = 8,
    parameter int M      = 4,
    parameter int SIGNED = 0,
    parameter int ACC_W  = N + clog2(M) + 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    adder_tree_acc_if.slave   io
);
    localparam int L     = clog2(M);
    localparam int SW    = N + L;
    localparam bit c_SGN = (SIGNED != 0);
    localparam logic [ACC_W-1:0] c_MAX = ACC_W'(sat_max(ACC_W, c_SGN));
    localparam logic [ACC_W-1:0] c_MIN = ACC_W'(sat_min(ACC_W, c_SGN));

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int W = N + k - 1;
        localparam int K = M >> (k - 1);

        logic [K*W-1:0]         w_din;
        logic                   w_vin;
        logic                   w_ain;
        logic                   w_cin;
        logic [(K/2)*(W+1)-1:0] w_dout;
        logic                   w_vout;
        logic                   w_aout;
        logic                   w_cout;

        if (k == 1) begin : g_head
            assign w_din = io.in_data;
            assign w_vin = io.in_valid;
            assign w_ain = io.in_acc;
            assign w_cin = io.in_clr;
        end else begin : g_link
            assign w_din = g_lvl[k-1].w_dout;
            assign w_vin = g_lvl[k-1].w_vout;
            assign w_ain = g_lvl[k-1].w_aout;
            assign w_cin = g_lvl[k-1].w_cout;
        end

        adder_stage #(
            .W      (W),
            .K      (K),
            .SIGNED (SIGNED)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_data  (w_din),
            .i_valid (w_vin),
            .i_acc   (w_ain),
            .i_clr   (w_cin),
            .o_data  (w_dout),
            .o_valid (w_vout),
            .o_acc   (w_aout),
            .o_clr   (w_cout)
        );
    end

    logic [SW-1:0]    w_tree;
    logic             w_tv;
    logic             w_ta;
    logic             w_tc;
    logic [ACC_W-1:0] w_s;
    logic [ACC_W:0]   w_t;
    logic             w_ovf;
    logic [ACC_W-1:0] w_next;

    logic [ACC_W-1:0] r_acc;
    logic             r_sat;
    logic             r_valid;

    assign w_tree = g_lvl[L].w_dout;
    assign w_tv   = g_lvl[L].w_vout;
    assign w_ta   = g_lvl[L].w_aout;
    assign w_tc   = g_lvl[L].w_cout;

    if (ACC_W > SW) begin : g_widen
        assign w_s = {{(ACC_W-SW){ext(w_tree[SW-1], c_SGN)}}, w_tree};
    end else begin : g_exact
        assign w_s = w_tree;
    end

    assign w_t = {ext(r_acc[ACC_W-1], c_SGN), r_acc} + {ext(w_s[ACC_W-1], c_SGN), w_s};

    // Signed overflow shows as disagreement between the guard bit and the MSB;
    // the guard bit then gives the direction of the overshoot.
    always_comb begin
        w_ovf  = 1'b0;
        w_next = w_t[ACC_W-1:0];
        if (c_SGN) w_ovf = w_t[ACC_W] ^ w_t[ACC_W-1];
        else       w_ovf = w_t[ACC_W];
        if (w_ovf) w_next = (c_SGN && w_t[ACC_W]) ? c_MIN : c_MAX;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_acc   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_valid <= w_tv;
            if (w_tv) begin
                if (!w_ta || w_tc) begin
                    r_acc <= w_s;
                    r_sat <= 1'b0;
                end else begin
                    r_acc <= w_next;
                    if (w_ovf) r_sat <= 1'b1;
                end
            end
        end
    end

    assign io.out_valid = r_valid;
    assign io.out_sum   = r_acc;
    assign io.out_sat   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_acc.sv
`default_nettype none
// =============================================================================
// Module   : tb_adder_tree_acc
// Brief    : Self-checking bench: unsigned ACC_W=14 and signed ACC_W=10 instances.
// Revision : 1.0 - initial release
// =============================================================================
module tb_adder_tree_acc;

    localparam int N    = 8;
    localparam int M    = 4;
    localparam int AW_A = 14;
    localparam int AW_B = 10;

    typedef struct { logic v; logic [31:0] d; logic a; logic c; } in_t;
    typedef struct { logic v; longint sum; logic sat; } out_t;
    typedef struct { in_t in; out_t exp; } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_tree_acc_if #(.N(N), .M(M), .ACC_W(AW_A)) bus_a ();
    adder_tree_acc_if #(.N(N), .M(M), .ACC_W(AW_B)) bus_b ();

    adder_tree_acc #(.N(N), .M(M), .SIGNED(0), .ACC_W(AW_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .io(bus_a));
    adder_tree_acc #(.N(N), .M(M), .SIGNED(1), .ACC_W(AW_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .io(bus_b));

    int     n_err = 0;
    int     n_chk = 0;
    longint acc_a, acc_b;
    logic   sat_a, sat_b;
    out_t   q_a[$];
    out_t   q_b[$];
    vec_t   tab_a[25];
    vec_t   tab_b[8];
    in_t    bub;

    function automatic in_t mk(input logic v, input logic [31:0] d, input logic a, input logic c);
        in_t x;
        x.v = v; x.d = d; x.a = a; x.c = c;
        return x;
    endfunction

    function automatic vec_t mkv(input in_t x, input logic v, input longint s, input logic st);
        vec_t r;
        r.in = x; r.exp.v = v; r.exp.sum = s; r.exp.sat = st;
        return r;
    endfunction

    // Reference: integer sum of operands, then accumulate/clamp by the rules.
    function automatic out_t model(input in_t x, input bit sgn, input int aw,
                                   inout longint acc, inout logic sat);
        longint s, mx, mn, t;
        logic [7:0] b;
        out_t r;
        s = 0;
        for (int i = 0; i < M; i++) begin
            b = x.d[i*8 +: 8];
            s += sgn ? longint'($signed(b)) : longint'(b);
        end
        mx = sgn ? (longint'(1) <<< (aw - 1)) - 1 : (longint'(1) <<< aw) - 1;
        mn = sgn ? -(longint'(1) <<< (aw - 1)) : 0;
        if (x.v) begin
            if (!x.a || x.c) begin
                acc = s; sat = 1'b0;
            end else begin
                t = acc + s;
                if (t > mx)      begin acc = mx; sat = 1'b1; end
                else if (t < mn) begin acc = mn; sat = 1'b1; end
                else             acc = t;
            end
        end
        r.v = x.v; r.sum = acc; r.sat = sat;
        return r;
    endfunction

    function automatic longint get_a();
        return longint'(bus_a.out_sum);
    endfunction

    function automatic longint get_b();
        return longint'($signed(bus_b.out_sum));
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        out_t z;
        z.v = 1'b0; z.sum = 0; z.sat = 1'b0;
        acc_a = 0; acc_b = 0; sat_a = 1'b0; sat_b = 1'b0;
        q_a.delete(); q_b.delete();
        repeat (2) begin
            q_a.push_back(z);
            q_b.push_back(z);
        end
    endtask

    task automatic drive(input in_t ia, input in_t ib);
        bus_a.in_valid = ia.v; bus_a.in_data = ia.d; bus_a.in_acc = ia.a; bus_a.in_clr = ia.c;
        bus_b.in_valid = ib.v; bus_b.in_data = ib.d; bus_b.in_acc = ib.a; bus_b.in_clr = ib.c;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a_valid"}, longint'(bus_a.out_valid), 0);
        chk({tag, "_a_sum"},   get_a(), 0);
        chk({tag, "_a_sat"},   longint'(bus_a.out_sat), 0);
        chk({tag, "_b_valid"}, longint'(bus_b.out_valid), 0);
        chk({tag, "_b_sum"},   get_b(), 0);
        chk({tag, "_b_sat"},   longint'(bus_b.out_sat), 0);
    endtask

    task automatic step(input in_t ia, input in_t ib);
        out_t ea, eb;
        drive(ia, ib);
        @(posedge clk);
        #1;
        q_a.push_back(model(ia, 1'b0, AW_A, acc_a, sat_a));
        q_b.push_back(model(ib, 1'b1, AW_B, acc_b, sat_b));
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        chk("mdl_a_valid", longint'(bus_a.out_valid), longint'(ea.v));
        chk("mdl_a_sum",   get_a(), ea.sum);
        chk("mdl_a_sat",   longint'(bus_a.out_sat), longint'(eb.v) * 0 + longint'(ea.sat));
        chk("mdl_b_valid", longint'(bus_b.out_valid), longint'(eb.v));
        chk("mdl_b_sum",   get_b(), eb.sum);
        chk("mdl_b_sat",   longint'(bus_b.out_sat), longint'(eb.sat));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bub = mk(1'b0, 32'h0, 1'b0, 1'b0);

        tab_a[0]  = mkv(mk(1, 32'hFFFFFFFF, 0, 0), 1, 1020, 0);
        tab_a[1]  = mkv(mk(1, 32'h0000000A, 0, 0), 1, 10, 0);
        tab_a[2]  = mkv(bub,                       0, 10, 0);
        tab_a[3]  = mkv(mk(1, 32'h05050505, 0, 0), 1, 20, 0);
        tab_a[4]  = mkv(mk(1, 32'h0000001E, 0, 0), 1, 30, 0);
        tab_a[5]  = mkv(mk(1, 32'hFAFAFAFA, 1, 1), 1, 1000, 0);
        for (int i = 6; i <= 20; i++)
            tab_a[i] = mkv(mk(1, 32'hFAFAFAFA, 1, 0), 1, longint'(1000 * (i - 4)), 0);
        tab_a[21] = mkv(mk(1, 32'hFAFAFAFA, 1, 0), 1, 16383, 1);
        tab_a[22] = mkv(bub,                       0, 16383, 1);
        tab_a[23] = mkv(mk(1, 32'h00000005, 1, 1), 1, 5, 0);
        tab_a[24] = mkv(mk(1, 32'h01010101, 0, 1), 1, 4, 0);

        tab_b[0] = mkv(mk(1, 32'h80808080, 0, 0), 1, -512, 0);
        tab_b[1] = mkv(mk(1, 32'h0100FF7F, 0, 0), 1, 127, 0);
        tab_b[2] = mkv(mk(1, 32'hCECECECE, 1, 1), 1, -200, 0);
        tab_b[3] = mkv(mk(1, 32'hCECECECE, 1, 0), 1, -400, 0);
        tab_b[4] = mkv(mk(1, 32'hCECECECE, 1, 0), 1, -512, 1);
        tab_b[5] = mkv(mk(1, 32'h19191919, 1, 0), 1, -412, 1);
        tab_b[6] = mkv(mk(1, 32'h7F7F7F7F, 1, 0), 1, 96, 1);
        tab_b[7] = mkv(mk(1, 32'h7F7F7F7F, 1, 0), 1, 511, 1);

        drive(bub, bub);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            if (i < 25) step(tab_a[i].in, bub);
            else        step(bub, bub);
            if (i >= 2) begin
                chk($sformatf("tab_a[%0d]_valid", i - 2), longint'(bus_a.out_valid), longint'(tab_a[i-2].exp.v));
                chk($sformatf("tab_a[%0d]_sum", i - 2),   get_a(), tab_a[i-2].exp.sum);
                chk($sformatf("tab_a[%0d]_sat", i - 2),   longint'(bus_a.out_sat), longint'(tab_a[i-2].exp.sat));
            end
        end

        for (int i = 0; i < 10; i++) begin
            if (i < 8) step(bub, tab_b[i].in);
            else       step(bub, bub);
            if (i >= 2) begin
                chk($sformatf("tab_b[%0d]_valid", i - 2), longint'(bus_b.out_valid), longint'(tab_b[i-2].exp.v));
                chk($sformatf("tab_b[%0d]_sum", i - 2),   get_b(), tab_b[i-2].exp.sum);
                chk($sformatf("tab_b[%0d]_sat", i - 2),   longint'(bus_b.out_sat), longint'(tab_b[i-2].exp.sat));
            end
        end

        for (int i = 0; i < 400; i++) begin
            in_t ra, rb;
            ra = mk($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0);
            rb = mk($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0);
            step(ra, rb);
        end

        // Reset with samples in flight: nothing accepted before it may emerge.
        step(mk(1, 32'h11111111, 0, 0), mk(1, 32'h01010101, 0, 0));
        step(mk(1, 32'h22222222, 0, 0), mk(1, 32'h02020202, 0, 0));
        drive(mk(1, 32'h33333333, 0, 0), mk(1, 32'h03030303, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        model_reset();
        drive(bub, bub);
        repeat (2) @(posedge clk);
        #1;
        chk_zero("in_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(1, 32'h00000007, 0, 0), mk(1, 32'h000000FD, 0, 0));
        step(bub, bub);
        chk("post_rst_no_early_a", longint'(bus_a.out_valid), 0);
        step(bub, bub);
        chk("post_rst_first_a_valid", longint'(bus_a.out_valid), 1);
        chk("post_rst_first_a_sum", get_a(), 7);
        chk("post_rst_first_b_sum", get_b(), -3);
        repeat (3) step(bub, bub);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
